// File: rtl/stopwatch_timer_ctrl.sv
// stopwatch_timer_ctrl - stopwatch / countdown timer FSM with count register and circular lap memory
// Rev 1.0 - initial release
`default_nettype none

module stopwatch_timer_ctrl #(
  parameter int WIDTH     = 16,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         tick,
  input  logic                         pb0,
  input  logic                         pb1,
  input  logic                         pb2,
  output logic [WIDTH-1:0]             count,
  output logic [WIDTH-1:0]             display,
  output logic [$clog2(LAP_DEPTH)-1:0] lap_idx,
  output logic [$clog2(LAP_DEPTH):0]   lap_cnt,
  output logic [1:0]                   mode,
  output logic                         running,
  output logic                         time_up
);

  localparam int IW = $clog2(LAP_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0]    LAPS_FULL = CW'(LAP_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SW_RUN   = 3'd1,
    SW_PAUSE = 3'd2,
    LAP_VIEW = 3'd3,
    T_SET    = 3'd4,
    T_RUN    = 3'd5,
    T_PAUSE  = 3'd6,
    T_UP     = 3'd7
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] laps [LAP_DEPTH];
  logic [IW-1:0]    wr_ptr, wr_ptr_nxt;
  logic [IW-1:0]    view, view_nxt;
  logic [CW-1:0]    lap_cnt_nxt;
  logic             lap_we;
  logic             view_last;
  logic [IW-1:0]    rd_idx;

  assign count_inc = (count == CNT_MAX) ? count : count + WIDTH'(1);
  assign count_dec = (count == '0) ? count : count - WIDTH'(1);
  assign view_last = ({1'b0, view} == (lap_cnt - CW'(1)));

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    wr_ptr_nxt  = wr_ptr;
    lap_cnt_nxt = lap_cnt;
    view_nxt    = view;
    lap_we      = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (pb0) begin
          state_nxt   = SW_RUN;
          wr_ptr_nxt  = '0;
          lap_cnt_nxt = '0;
          view_nxt    = '0;
        end else if (pb1) begin
          state_nxt = T_SET;
        end
      end
      SW_RUN: begin
        if (tick) count_nxt = count_inc;
        if (pb0) begin
          state_nxt = SW_PAUSE;
        end else if (pb1) begin
          // Lap captures the pre-tick count; oldest entry is overwritten once full
          lap_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + IW'(1);
          if (lap_cnt != LAPS_FULL) lap_cnt_nxt = lap_cnt + CW'(1);
        end
      end
      SW_PAUSE: begin
        if (pb0) begin
          state_nxt = SW_RUN;
        end else if (pb1) begin
          if (lap_cnt != '0) begin
            state_nxt = LAP_VIEW;
            view_nxt  = '0;
          end
        end else if (pb2) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      LAP_VIEW: begin
        if (pb0) begin
          state_nxt = SW_PAUSE;
        end else if (pb1) begin
          view_nxt = view_last ? '0 : view + IW'(1);
        end else if (pb2) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      T_SET: begin
        if (pb0) begin
          if (count != '0) state_nxt = T_RUN;
        end else if (pb1 && pb2) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (pb1) begin
          count_nxt = count_dec;
        end else if (pb2) begin
          count_nxt = count_inc;
        end
      end
      T_RUN: begin
        // Expiry takes precedence over a simultaneous pause request
        if (tick && (count <= WIDTH'(1))) begin
          count_nxt = '0;
          state_nxt = T_UP;
        end else begin
          if (tick) count_nxt = count_dec;
          if (pb0) state_nxt = T_PAUSE;
        end
      end
      T_PAUSE: begin
        if (pb0) begin
          state_nxt = (count == '0) ? T_UP : T_RUN;
        end else if (pb1) begin
          state_nxt = T_SET;
        end else if (pb2) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      T_UP: begin
        count_nxt = '0;
        if (pb0) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      count   <= '0;
      wr_ptr  <= '0;
      lap_cnt <= '0;
      view    <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      wr_ptr  <= wr_ptr_nxt;
      lap_cnt <= lap_cnt_nxt;
      view    <= view_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
    end else if (lap_we) begin
      laps[wr_ptr] <= count;
    end
  end

  // Once the ring has wrapped, the oldest lap sits at the write pointer
  assign rd_idx = ((lap_cnt == LAPS_FULL) ? wr_ptr : '0) + view;

  always_comb begin
    display = count;
    lap_idx = '0;
    if (state == LAP_VIEW) begin
      display = laps[rd_idx];
      lap_idx = view;
    end
  end

  always_comb begin
    mode = 2'd0;
    case (state)
      SW_RUN, SW_PAUSE, LAP_VIEW: mode = 2'd1;
      T_SET, T_RUN, T_PAUSE:      mode = 2'd2;
      T_UP:                       mode = 2'd3;
      default:                    mode = 2'd0;
    endcase
  end

  assign running = (state == SW_RUN) || (state == T_RUN);
  assign time_up = (state == T_UP);

endmodule

`default_nettype wire

// File: doc/stopwatch_timer_ctrl.md
# stopwatch_timer_ctrl

Parametrised stopwatch/countdown-timer controller with an integrated count register and a circular lap memory. It sits between the debounced push-button pulses / prescaler tick and the display driver. It owns the mode FSM and the count datapath and selects the value to show. Unlike the earlier enable-strobe FSM, it has pause/resume, lap capture and lap review, and a saturating settable countdown with a time-up state.

## Interface
- WIDTH, 16, count/lap/display width in bits (≥4)
- LAP_DEPTH, 4, number of lap entries; power of two, ≥2
- clk  in  1  system clock
- nrst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle count-rate strobe from prescaler
- pb0  in  1  start/stop/mode pulse (single-cycle, debounced upstream)
- pb1  in  1  lap/select/decrement pulse (single-cycle)
- pb2  in  1  clear/increment pulse (single-cycle)
- count  out  WIDTH  live count register
- display  out  WIDTH  count, or selected lap in LAP_VIEW
- lap_idx  out  $clog2(LAP_DEPTH)  view position in LAP_VIEW (0 = oldest), else 0
- lap_cnt  out  $clog2(LAP_DEPTH)+1  valid laps stored (0..LAP_DEPTH)
- mode  out  2  0 idle, 1 stopwatch states, 2 timer states, 3 T_UP
- running  out  1  high in SW_RUN or T_RUN
- time_up  out  1  high in T_UP

## Operation
- States: IDLE, SW_RUN, SW_PAUSE, LAP_VIEW, T_SET, T_RUN, T_PAUSE, T_UP.
- Button priority, same cycle: pb0 > pb1 > pb2. Exception: in T_SET, pb1&pb2 together → IDLE.
- IDLE: count held at 0.
  - pb0 → SW_RUN; clears wr_ptr, lap_cnt and view index.
  - pb1 → T_SET.
- SW_RUN: tick → count+1, saturating at 2^WIDTH−1 (no wrap).
  - pb0 → SW_PAUSE.
  - pb1 → write current count register value (pre-tick) to lap[wr_ptr]. wr_ptr+1 mod LAP_DEPTH; lap_cnt+1, saturating at LAP_DEPTH. Once full, the oldest entry is overwritten.
- SW_PAUSE: count frozen.
  - pb0 → SW_RUN.
  - pb1 → LAP_VIEW (view=0) if lap_cnt>0, else no effect.
  - pb2 → IDLE.
- LAP_VIEW: display = lap[(base+view) mod LAP_DEPTH], where base = wr_ptr if lap_cnt==LAP_DEPTH, else 0.
  - pb1 → view+1, wrapping to 0 after lap_cnt−1.
  - pb0 → SW_PAUSE.
  - pb2 → IDLE.
  - tick ignored.
- T_SET:
  - pb2 alone → count+1, saturating at max.
  - pb1 alone → count−1, saturating at 0.
  - pb0 → T_RUN if count≠0, else ignored.
- T_RUN: tick → count−1.
  - A tick at count==1 loads 0 and enters T_UP on the same edge.
  - pb0 → T_PAUSE; pb1/pb2 ignored.
- T_PAUSE:
  - pb0 → T_RUN (or T_UP if count==0).
  - pb1 → T_SET, keeping count.
  - pb2 → IDLE.
- T_UP: count=0, time_up=1; pb0 → IDLE; other inputs ignored.
- Tick and pb0 in the same cycle in a RUN state: the tick is applied, then the transition occurs.
- Lap memory is not cleared on entry to IDLE; only SW start or reset clears lap_cnt.

## Timing
- All state, count, lap memory and pointers are registered on posedge clk.
- mode, running, time_up, display and lap_idx are combinational decodes of registered state. They are valid in the cycle after the causing edge.
- Button/tick to count or state change: 1 cycle.
- Lap capture: the entry is readable in LAP_VIEW starting the cycle after the write edge.
- Reset (async, any state, including mid-count): state=IDLE, count=0, all lap entries=0, wr_ptr=0, view=0, lap_cnt=0. Resulting outputs: display=0, mode=0, running=0, time_up=0.
- No combinational path from inputs to outputs.

## Test plan
(WIDTH=8, LAP_DEPTH=4 throughout.)
- Stopwatch count/pause: pb0, then 5 ticks, then pb0, then 3 ticks → count=5, state SW_PAUSE, running=0.
- Lap wrap: in SW_RUN, pb1 at count 1,2,3,4,5 → lap_cnt=4. In LAP_VIEW, pb1 presses step display 2,3,4,5,2.
- Saturation: SW_RUN with 300 ticks → count=255, holds. T_SET with pb1 at count 0 → stays 0; pb0 there is ignored.
- Timer: pb1, then pb2×3, then pb0, then 3 ticks → time_up=1 exactly one cycle after the third tick edge, count=0. Then pb0 → IDLE.
- Simultaneous events: SW_RUN at count=7 with tick+pb1 together → lap=7, count=8. T_SET with pb1+pb2 together → IDLE.
- Reset mid-T_RUN at count=9 → next cycle count=0, mode=0, lap_cnt=0. Outputs hold through deassert.
